// File: rtl/glyph.sv
// Text-mode hex glyph renderer: maps the beam position on a 640x480 raster to
// the font row of its 8x8 cell and the pixel bit under the beam, one clock later.
module glyph #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] vertical,
  input  logic [9:0] horizontal,
  output logic       pix,
  output logic [7:0] bitmap
);

  // One 64-bit word per glyph, row 0 in the top byte.
  localparam logic [63:0] FONT [0:15] = '{
    64'h3C666E7666663C00,
    64'h1838181818187E00,
    64'h3C66060C30607E00,
    64'h3C66061C06663C00,
    64'h0C1C3C6C7E0C0C00,
    64'h7E607C0606663C00,
    64'h1C30607C66663C00,
    64'h7E060C1830303000,
    64'h3C66663C66663C00,
    64'h3C66663E060C3800,
    64'h183C66667E666600,
    64'h7C66667C66667C00,
    64'h3C66606060663C00,
    64'h786C6666666C7800,
    64'h7E60607C60607E00,
    64'h7E60607C60606000
  };

  logic [3:0]  code;
  logic [2:0]  row;
  logic [2:0]  col;
  logic [63:0] glyph_word;
  logic [7:0]  row_bits;
  logic        visible;

  // Only the low 4 bits of cx + cy matter, so the sum is formed on 4 bits.
  assign code       = horizontal[6:3] + vertical[6:3];
  assign row        = vertical[2:0];
  assign col        = horizontal[2:0];
  assign glyph_word = FONT[code];
  assign row_bits   = glyph_word[{~row, 3'b000} +: 8];
  assign visible    = (32'(horizontal) < H_ACTIVE) && (32'(vertical) < V_ACTIVE);

  always_ff @(posedge clk) begin
    if (reset) begin
      bitmap <= 8'h00;
      pix    <= 1'b0;
    end else if (!visible) begin
      bitmap <= 8'h00;
      pix    <= 1'b0;
    end else begin
      bitmap <= row_bits;
      pix    <= row_bits[~col];
    end
  end

endmodule

// File: tb/tb_glyph.sv
// Bench for glyph: directed cases from the test plan, a full line sweep and
// randomized coordinates compared against a cell/row/column arithmetic model.
module tb_glyph;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] vertical = '0;
  logic [9:0] horizontal = '0;
  logic       pix;
  logic [7:0] bitmap;

  int checks = 0;
  int errors = 0;

  glyph dut (
    .clk        (clk),
    .reset      (reset),
    .vertical   (vertical),
    .horizontal (horizontal),
    .pix        (pix),
    .bitmap     (bitmap)
  );

  always #5 clk = ~clk;

  logic [7:0] font [0:15][0:7] = '{
    '{8'h3C, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h66, 8'h3C, 8'h00},
    '{8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00},
    '{8'h3C, 8'h66, 8'h06, 8'h0C, 8'h30, 8'h60, 8'h7E, 8'h00},
    '{8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h66, 8'h3C, 8'h00},
    '{8'h0C, 8'h1C, 8'h3C, 8'h6C, 8'h7E, 8'h0C, 8'h0C, 8'h00},
    '{8'h7E, 8'h60, 8'h7C, 8'h06, 8'h06, 8'h66, 8'h3C, 8'h00},
    '{8'h1C, 8'h30, 8'h60, 8'h7C, 8'h66, 8'h66, 8'h3C, 8'h00},
    '{8'h7E, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h30, 8'h30, 8'h00},
    '{8'h3C, 8'h66, 8'h66, 8'h3C, 8'h66, 8'h66, 8'h3C, 8'h00},
    '{8'h3C, 8'h66, 8'h66, 8'h3E, 8'h06, 8'h0C, 8'h38, 8'h00},
    '{8'h18, 8'h3C, 8'h66, 8'h66, 8'h7E, 8'h66, 8'h66, 8'h00},
    '{8'h7C, 8'h66, 8'h66, 8'h7C, 8'h66, 8'h66, 8'h7C, 8'h00},
    '{8'h3C, 8'h66, 8'h60, 8'h60, 8'h60, 8'h66, 8'h3C, 8'h00},
    '{8'h78, 8'h6C, 8'h66, 8'h66, 8'h66, 8'h6C, 8'h78, 8'h00},
    '{8'h7E, 8'h60, 8'h60, 8'h7C, 8'h60, 8'h60, 8'h7E, 8'h00},
    '{8'h7E, 8'h60, 8'h60, 8'h7C, 8'h60, 8'h60, 8'h60, 8'h00}
  };

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_bitmap(input int h, input int v, input bit rst);
    int cx, cy;
    if (rst || h >= 640 || v >= 480) return 8'h00;
    cx = h / 8;
    cy = v / 8;
    return font[(cx + cy) % 16][v % 8];
  endfunction

  function automatic logic model_pix(input int h, input int v, input bit rst);
    logic [7:0] b;
    b = model_bitmap(h, v, rst);
    return b[7 - (h % 8)];
  endfunction

  // Apply coordinates, let one rising edge take them, then look just after it.
  task automatic apply(input int h, input int v, input bit rst);
    horizontal = 10'(h);
    vertical   = 10'(v);
    reset      = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input int h, input int v, input bit rst);
    apply(h, v, rst);
    check({tag, ".bitmap"}, 32'(bitmap), 32'(model_bitmap(h, v, rst)));
    check({tag, ".pix"}, 32'(pix), 32'(model_pix(h, v, rst)));
  endtask

  task automatic step_lit(input string tag, input int h, input int v, input bit rst,
                          input logic [7:0] exp_bm, input logic exp_px);
    apply(h, v, rst);
    check({tag, ".bitmap"}, 32'(bitmap), 32'(exp_bm));
    check({tag, ".pix"}, 32'(pix), 32'(exp_px));
  endtask

  initial begin
    int h, v;
    bit rst;

    // Reset held with a visible coordinate, then released.
    step_lit("rst0", 2, 0, 1'b1, 8'h00, 1'b0);
    step_lit("rst1", 2, 0, 1'b1, 8'h00, 1'b0);
    step_lit("rel", 2, 0, 1'b0, 8'h3C, 1'b1);

    // Origin cell.
    step_lit("org_h0", 0, 0, 1'b0, 8'h3C, 1'b0);
    step_lit("org_h2", 2, 0, 1'b0, 8'h3C, 1'b1);
    step_lit("org_h7", 7, 0, 1'b0, 8'h3C, 1'b0);

    // Adjacent cell and row.
    step_lit("c10_h8", 8, 1, 1'b0, 8'h38, 1'b0);
    step_lit("c10_h10", 10, 1, 1'b0, 8'h38, 1'b1);
    for (int i = 0; i < 8; i++) begin
      h = $urandom_range(0, 639);
      step_lit("row7", h, 7, 1'b0, 8'h00, 1'b0);
    end

    // Code wrap-around.
    step_lit("wrap15_1", 120, 8, 1'b0, 8'h3C, 1'b0);
    step_lit("wrap79_59", 632, 472, 1'b0, 8'h18, 1'b0);

    // Blanking.
    step_lit("blank_h", 640, 0, 1'b0, 8'h00, 1'b0);
    step_lit("blank_v", 0, 480, 1'b0, 8'h00, 1'b0);
    step_lit("blank_hv", 1023, 1023, 1'b0, 8'h00, 1'b0);
    step_lit("edge_vis", 639, 479, 1'b0, model_bitmap(639, 479, 1'b0), model_pix(639, 479, 1'b0));

    // Held coordinate stays stable.
    for (int i = 0; i < 4; i++) step("hold", 333, 211, 1'b0);

    // Full line sweep on v=0 with a mid-line reset pulse.
    for (int n = 0; n < 640; n++) begin
      rst = (n == 300);
      step("sweep", n, 0, rst);
    end

    // Randomized coordinates, some blanking, occasional holds and resets.
    h = 0;
    v = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 9))
          0: begin h = $urandom_range(640, 1023); v = $urandom_range(0, 1023); end
          1: begin h = $urandom_range(0, 1023); v = $urandom_range(480, 1023); end
          default: begin h = $urandom_range(0, 639); v = $urandom_range(0, 479); end
        endcase
      end
      rst = ($urandom_range(0, 49) == 0);
      step("rand", h, v, rst);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/glyph.md
Name: glyph

Overview:
- Text-mode glyph renderer for a 640x480 raster.
- Takes the current pixel coordinates from the VGA timing block. Returns the 8-pixel font row for the character cell under the beam, plus the single pixel bit at that position.
- The screen is tiled into 8x8 cells, 80x60 cells in total. Each cell shows a hex-digit glyph from an internal font ROM.
- The outputs feed the colour mux that drives the display.

Parameters:
- H_ACTIVE, 640, number of visible columns. horizontal >= H_ACTIVE is blanking.
- V_ACTIVE, 480, number of visible rows. vertical >= V_ACTIVE is blanking.

Ports:
- clk  input  1  system clock; rising edge active.
- reset  input  1  synchronous, active-high reset.
- vertical  input  10  current pixel row, 0..V_ACTIVE-1 when visible.
- horizontal  input  10  current pixel column, 0..H_ACTIVE-1 when visible.
- pix  output  1  pixel value: 1 = foreground, 0 = background.
- bitmap  output  8  font row for the current cell. bit7 is the leftmost pixel.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). All state changes on the rising edge of clk.
- Reset: while reset=1 at a rising edge, bitmap <= 8'h00 and pix <= 0. Reset takes priority over every other action. Asserting reset mid-frame clears the outputs on that edge; normal output resumes on the first edge after reset deasserts.
- Decode, combinational from the inputs:
  - cx = horizontal[9:3], range 0..79.
  - cy = vertical[9:3], range 0..59.
  - row = vertical[2:0].
  - col = horizontal[2:0].
- Glyph code: code = (cx + cy) mod 16, i.e. the low 4 bits of a 7-bit sum. Wrap-around is required, e.g. cx=15, cy=1 gives code 0.
- Font ROM: 16 glyphs x 8 rows x 8 bits, synchronous or combinational read. Contents in hex, rows 0..7:
  - 0: 3C 66 6E 76 66 66 3C 00
  - 1: 18 38 18 18 18 18 7E 00
  - 2: 3C 66 06 0C 30 60 7E 00
  - 3: 3C 66 06 1C 06 66 3C 00
  - 4: 0C 1C 3C 6C 7E 0C 0C 00
  - 5: 7E 60 7C 06 06 66 3C 00
  - 6: 1C 30 60 7C 66 66 3C 00
  - 7: 7E 06 0C 18 30 30 30 00
  - 8: 3C 66 66 3C 66 66 3C 00
  - 9: 3C 66 66 3E 06 0C 38 00
  - A: 18 3C 66 66 7E 66 66 00
  - B: 7C 66 66 7C 66 66 7C 00
  - C: 3C 66 60 60 60 66 3C 00
  - D: 78 6C 66 66 66 6C 78 00
  - E: 7E 60 60 7C 60 60 7E 00
  - F: 7E 60 60 7C 60 60 60 00
- Outputs, registered:
  - bitmap <= ROM[code][row].
  - pix <= ROM[code][row][7 - col].
  - Latency is exactly 1 clk: outputs reflect the coordinates sampled at the previous rising edge.
  - pix and bitmap are always mutually consistent for the same sampled coordinate.
- Blanking: if horizontal >= H_ACTIVE or vertical >= V_ACTIVE at the sampling edge, bitmap <= 0 and pix <= 0.
- Coordinates may change every cycle or be held for many cycles. If held, the outputs are stable after the first edge.
- No handshake; no other state.

Test Plan:
- Reset: hold reset=1 with h=2, v=0 for 2 clocks -> bitmap=00, pix=0. Release reset -> after 1 clk, bitmap=3C, pix=1.
- Origin cell: v=0, h=0 -> bitmap=3C, pix=0 (bit7). Then h=2 -> pix=1 (bit5). h=7 -> pix=0.
- Adjacent cell and row: v=1, h=8 gives cell (1,0), glyph 1, row 1 -> bitmap=38, pix=0. h=10 -> pix=1. v=7, any h in 0..639 within that cell row -> bitmap=00, pix=0.
- Code wrap: h=120, v=8 gives cx=15, cy=1, code 0 -> bitmap=3C. h=632, v=472 gives cx=79, cy=59, code 10 (A), row 0 -> bitmap=18.
- Blanking: h=640, v=0 -> bitmap=00, pix=0. h=0, v=480 -> 00, 0. h=1023, v=1023 -> 00, 0.
- Latency and scan: sweep h 0..639 each clock on v=0. pix at cycle n+1 equals the expected bit for h=n. Assert reset mid-line -> outputs 0 on the next edge.
